// File: rtl/dvs_event_arbiter.sv
// Round-robin arbiter merging NUM_SRC_P DVS event streams into one registered
// output stage, with bounded burst locking per granted source.
module dvs_event_arbiter #(
  parameter int unsigned NUM_SRC_P   = 4,
  parameter int unsigned WIDTH_P     = 8,
  parameter int unsigned HEIGHT_P    = 8,
  parameter int unsigned MAX_BURST_P = 4,
  localparam int unsigned XW = $clog2(WIDTH_P),
  localparam int unsigned YW = $clog2(HEIGHT_P),
  localparam int unsigned SW = $clog2(NUM_SRC_P),
  localparam int unsigned TW = 16
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [NUM_SRC_P-1:0]    valid_i,
  input  logic [NUM_SRC_P*XW-1:0] x_i,
  input  logic [NUM_SRC_P*YW-1:0] y_i,
  input  logic [NUM_SRC_P-1:0]    polarity_i,
  input  logic [NUM_SRC_P*TW-1:0] timestamp_i,
  output logic [NUM_SRC_P-1:0]    ready_o,
  output logic                    valid_o,
  output logic [XW-1:0]           x_o,
  output logic [YW-1:0]           y_o,
  output logic                    polarity_o,
  output logic [TW-1:0]           timestamp_o,
  output logic [SW-1:0]           src_o,
  input  logic                    ready_i
);

  localparam int unsigned CW = $clog2(MAX_BURST_P + 1);

  typedef enum logic {IDLE, LOCKED} mode_e;

  typedef struct packed {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          polarity;
    logic [TW-1:0] timestamp;
    logic [SW-1:0] src;
  } evt_t;

  mode_e         mode_q, mode_d;
  logic [SW-1:0] ptr_q, ptr_d;
  logic [SW-1:0] cur_q, cur_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          valid_q;
  evt_t          evt_q, evt_d;
  logic          load_en;
  logic          accept;
  logic          gnt_vld;
  logic [SW-1:0] gnt_idx;

  function automatic logic [SW-1:0] mod_add(input logic [SW-1:0] a, input int unsigned b);
    return SW'((32'(a) + b) % NUM_SRC_P);
  endfunction

  // Grant selection: locked source only, else first valid from ptr onward.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    if (mode_q == LOCKED) begin
      gnt_vld = valid_i[cur_q];
      gnt_idx = cur_q;
    end else begin
      for (int i = int'(NUM_SRC_P) - 1; i >= 0; i--) begin
        if (valid_i[mod_add(ptr_q, 32'(i))]) begin
          gnt_vld = 1'b1;
          gnt_idx = mod_add(ptr_q, 32'(i));
        end
      end
    end
  end

  assign load_en = !valid_q || ready_i;
  assign accept  = load_en && gnt_vld && !reset_i;
  assign ready_o = accept ? (NUM_SRC_P'(1) << gnt_idx) : '0;

  always_comb begin
    evt_d           = '0;
    evt_d.x         = x_i[gnt_idx*XW +: XW];
    evt_d.y         = y_i[gnt_idx*YW +: YW];
    evt_d.polarity  = polarity_i[gnt_idx];
    evt_d.timestamp = timestamp_i[gnt_idx*TW +: TW];
    evt_d.src       = gnt_idx;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      mode_q <= IDLE;
      ptr_q  <= '0;
      cur_q  <= '0;
      cnt_q  <= '0;
    end else begin
      mode_q <= mode_d;
      ptr_q  <= ptr_d;
      cur_q  <= cur_d;
      cnt_q  <= cnt_d;
    end
  end

  // Lock release on a dropped valid takes precedence and ignores backpressure.
  always_comb begin
    mode_d = mode_q;
    ptr_d  = ptr_q;
    cur_d  = cur_q;
    cnt_d  = cnt_q;
    if (mode_q == LOCKED && !valid_i[cur_q]) begin
      mode_d = IDLE;
      ptr_d  = mod_add(cur_q, 32'd1);
      cnt_d  = '0;
    end else if (accept) begin
      if (mode_q == IDLE) begin
        if (MAX_BURST_P == 1) begin
          ptr_d = mod_add(gnt_idx, 32'd1);
        end else begin
          mode_d = LOCKED;
          cur_d  = gnt_idx;
          cnt_d  = CW'(1);
        end
      end else if (32'(cnt_q) + 32'd1 == MAX_BURST_P) begin
        mode_d = IDLE;
        ptr_d  = mod_add(cur_q, 32'd1);
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Output stage: load on accept, drain when emptied without a reload.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      valid_q <= 1'b0;
      evt_q   <= '0;
    end else if (accept) begin
      valid_q <= 1'b1;
      evt_q   <= evt_d;
    end else if (load_en) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o     = valid_q;
  assign x_o         = evt_q.x;
  assign y_o         = evt_q.y;
  assign polarity_o  = evt_q.polarity;
  assign timestamp_o = evt_q.timestamp;
  assign src_o       = evt_q.src;

endmodule

// File: doc/dvs_event_arbiter.md
# dvs_event_arbiter

Round-robin arbiter that merges NUM_SRC_P independent DVS event streams (one per sensor tap/quadrant) into the single event stream feeding the event buffer FIFO. Each input is a valid/ready event port carrying x, y, polarity and a 16-bit timestamp. The output is a registered single-entry pipeline stage tagged with the winning source index. Bounded burst locking lets a busy source send up to MAX_BURST_P back-to-back events before priority rotates.

## Interface
- NUM_SRC_P, 4: number of event sources, at least 2.
- WIDTH_P, 8: sensor width in pixels. XW = $clog2(WIDTH_P).
- HEIGHT_P, 8: sensor height in pixels. YW = $clog2(HEIGHT_P).
- MAX_BURST_P, 4: maximum consecutive accepted events from one source per grant, at least 1. SW = $clog2(NUM_SRC_P).

Ports:
- clk_i  in  1  the single clock.
- reset_i  in  1  asynchronous, active-high reset.
- valid_i  in  NUM_SRC_P  per-source event valid.
- x_i  in  NUM_SRC_P*XW  packed x; source k occupies [k*XW +: XW].
- y_i  in  NUM_SRC_P*YW  packed y, same packing as x_i.
- polarity_i  in  NUM_SRC_P  per-source polarity.
- timestamp_i  in  NUM_SRC_P*16  packed timestamps.
- ready_o  out  NUM_SRC_P  per-source accept; at most one bit high.
- valid_o  out  1  output event valid.
- x_o  out  XW  output x.
- y_o  out  YW  output y.
- polarity_o  out  1  output polarity.
- timestamp_o  out  16  output timestamp.
- src_o  out  SW  index of the source that produced the output event.
- ready_i  in  1  downstream (FIFO) ready.

## Operation
- State: mode (IDLE or LOCKED), ptr (SW bits, rotating priority), cur (SW bits, locked source), cnt (counts accepted events in the current lock), and the output register.
- load_en = !valid_o || ready_i.
- IDLE grant: the first k with valid_i[k]=1, searching ptr, ptr+1, … modulo NUM_SRC_P. No grant if all sources are low.
- LOCKED grant: cur if valid_i[cur]=1. Otherwise no grant that cycle; next state is IDLE with ptr=(cur+1) mod NUM_SRC_P and cnt=0. This release happens regardless of load_en.
- ready_o[k] = load_en && grant exists && grant==k. ready_o may depend combinationally on valid_i and ready_i. valid_o never depends combinationally on any input.
- Accept occurs when valid_i[g] && ready_o[g]. On accept, the output register loads source g's fields and src_o=g.
- IDLE accept:
  - If MAX_BURST_P==1: ptr=(g+1) mod N, stay IDLE.
  - Otherwise: go to LOCKED with cur=g and cnt=1.
- LOCKED accept:
  - cnt+1 == MAX_BURST_P: go to IDLE with ptr=(cur+1) mod N and cnt=0.
  - Otherwise: cnt increments.
- Stall (load_en=0): mode, ptr, cur and cnt hold. Exception: the LOCKED release on valid_i[cur]=0 still applies. Output fields hold stable while valid_o && !ready_i.
- Drain without reload: if valid_o && ready_i and there is no accept, valid_o goes to 0.
- ptr wraps from NUM_SRC_P-1 to 0. Arithmetic is modulo NUM_SRC_P, so non-power-of-2 values are supported.
- Fields are passed unmodified; no timestamp reordering across sources.

## Timing
- Reset values (asynchronous): valid_o=0, x_o/y_o/polarity_o/timestamp_o/src_o=0, mode=IDLE, ptr=0, cur=0, cnt=0. ready_o is all zeros while reset_i is high.
- Latency: an event accepted at edge t is visible at valid_o after edge t, i.e. one cycle.
- Throughput: one event per cycle when ready_i stays high, including consecutive events from different sources.
- A LOCKED source dropping valid costs exactly one idle grant cycle.
- Reset asserted mid-burst or with valid_o=1: the pending event is discarded and state returns to reset values immediately. The first grant after deassertion searches from source 0.

## Test plan
- Priority and lock: N=4, MAX_BURST_P=4, all valid_i=1, ready_i=1 held, continuous streams. Required accepted source sequence is 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0…, with src_o matching one cycle later.
- Per-source exactness: sources 1 and 3 only, each with distinct incrementing timestamps 0x0100+i and 0x0300+i. Required order is 1×4 then 3×4, alternating. x/y/polarity/timestamp match the sender exactly, with no loss or duplication.
- Lock release: source 2 sends 2 events then drops valid while source 0 is valid. Required: one cycle with ready_o=0, then ptr=3 and the next grant goes to source 0 via wrap-around.
- Backpressure: ready_i=0 for 5 cycles with valid_o=1. Required: output fields stable, ready_o=0 for all sources, cnt unchanged. On ready_i=1, the event drains and the next is accepted in the same cycle.
- MAX_BURST_P=1 with all sources valid. Required: strict rotation 0,1,2,3,0; mode never LOCKED.
- Reset during burst: assert reset_i asynchronously mid-cycle after 2 events from source 1. Required: valid_o=0 before the next edge. After release with all valid, the first grant goes to source 0.
